// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and default sizes for the NCO voice scheduler
package nco_pkg;

  localparam int DSZ_DEF = 24;
  localparam int NV_DEF  = 4;
  localparam int VW_DEF  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [VW_DEF-1:0] voice_t;

endpackage

// File: rtl/nco_voice_sched_if.sv
// rtl/nco_voice_sched_if.sv - control/sample bundle between register path and voice scheduler
interface nco_voice_sched_if
  import nco_pkg::*;
#(
  parameter int dsz = DSZ_DEF,
  parameter int VW  = VW_DEF
);

  logic           ena;
  logic           wr_stb;
  logic [VW-1:0]  wr_addr;
  logic [dsz-1:0] wr_frq;
  logic           phs_clr;
  logic [dsz-1:0] phs;
  logic           phs_vld;
  logic [VW-1:0]  phs_voice;
  logic           busy;
  logic           ovr;

  modport master (
    output ena, wr_stb, wr_addr, wr_frq, phs_clr,
    input  phs, phs_vld, phs_voice, busy, ovr
  );

  modport slave (
    input  ena, wr_stb, wr_addr, wr_frq, phs_clr,
    output phs, phs_vld, phs_voice, busy, ovr
  );

endinterface

// File: rtl/nco_frq_regs.sv
// rtl/nco_frq_regs.sv - per-voice frequency word file, one sync write port, one comb read port
module nco_frq_regs
  import nco_pkg::*;
#(
  parameter int dsz = DSZ_DEF,
  parameter int NV  = NV_DEF,
  parameter int VW  = VW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [VW-1:0]  wr_addr,
  input  logic [dsz-1:0] wr_data,
  input  logic [VW-1:0]  rd_addr,
  output logic [dsz-1:0] rd_data
);

  logic [dsz-1:0] mem [NV];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NV; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // read sees the pre-edge contents, so a same-cycle write only affects later rounds
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nco_voice_sched.sv
// rtl/nco_voice_sched.sv - one shared phase adder walked across all voices on each sample tick
module nco_voice_sched
  import nco_pkg::*;
#(
  parameter int dsz = DSZ_DEF,
  parameter int NV  = NV_DEF,
  parameter int VW  = VW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  nco_voice_sched_if.slave   bus
);

  state_t         state, state_nxt;
  logic [VW-1:0]  v, v_nxt;
  logic           busy_nxt;
  logic           ovr_nxt;
  logic           upd;
  logic [dsz-1:0] phase [NV];
  logic [dsz-1:0] frq_rd;
  logic [dsz-1:0] sum;

  nco_frq_regs #(
    .dsz (dsz),
    .NV  (NV),
    .VW  (VW)
  ) u_frq (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_stb),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_frq),
    .rd_addr (v),
    .rd_data (frq_rd)
  );

  assign sum = phase[v] + frq_rd;

  always_comb begin
    state_nxt = state;
    v_nxt     = v;
    busy_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    upd       = 1'b0;
    if (bus.phs_clr) begin
      // clear aborts any round and swallows a coincident tick
      state_nxt = ST_IDLE;
      v_nxt     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ena) begin
            state_nxt = ST_RUN;
            v_nxt     = '0;
            busy_nxt  = 1'b1;
          end
        end
        ST_RUN: begin
          upd      = 1'b1;
          busy_nxt = 1'b1;
          ovr_nxt  = bus.ena;
          v_nxt    = v + 1'b1;
          if (v == VW'(NV - 1)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      v     <= '0;
    end else begin
      state <= state_nxt;
      v     <= v_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.phs_clr) begin
      for (int i = 0; i < NV; i++) phase[i] <= '0;
    end else if (upd) begin
      phase[v] <= sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.phs       <= '0;
      bus.phs_voice <= '0;
      bus.phs_vld   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.ovr       <= 1'b0;
    end else begin
      bus.phs_vld <= upd;
      bus.busy    <= busy_nxt;
      bus.ovr     <= ovr_nxt;
      if (upd) begin
        bus.phs       <= sum;
        bus.phs_voice <= v;
      end
    end
  end

endmodule

// File: doc/nco_voice_sched.md
Name: nco_voice_sched

Overview:
Time-multiplexed scheduler that shares one phase-accumulator adder among NV oscillator voices. On each sample tick it walks every voice in order and adds that voice's frequency word to its stored phase. It emits one registered phase sample per cycle, tagged with the voice index. It sits between the control-register write path and the per-voice DAC/waveshaper pipeline, replacing NV separate accumulators.

Parameters:
dsz, 24, phase accumulator and frequency word width
NV, 4, number of voices (power of two, >=2)
VW, 2, voice index width, log2(NV)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ena  in  1  sample tick, 1-cycle pulse; starts one scheduling round
wr_stb  in  1  frequency write strobe
wr_addr  in  VW  voice index for the frequency write
wr_frq  in  dsz  frequency word to write
phs_clr  in  1  synchronous clear of all voice phases
phs  out  dsz  updated phase of the current voice
phs_vld  out  1  phs/phs_voice are valid this cycle
phs_voice  out  VW  voice index of phs
busy  out  1  scheduling round in progress
ovr  out  1  1-cycle pulse: ena arrived while busy (tick dropped)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, all frequency regs=0, all phase regs=0, phs=0, phs_vld=0, phs_voice=0, busy=0, ovr=0. Reset overrides every other input. Reset asserted mid-round aborts the round immediately; no further phs_vld.
- States: IDLE and RUN. Internal voice counter v (VW bits).
- IDLE: if ena=1 at edge k, go to RUN with v=0 and set busy=1 from edge k.
- RUN, at each edge k+1+i for i=0..NV-1:
  - phase[i] <= phase[i] + frq[i], modulo 2^dsz (wrap, no saturation).
  - phs <= new phase[i]; phs_voice <= i; phs_vld <= 1.
  - v increments.
  - After i=NV-1, return to IDLE. busy=0 and phs_vld=0 from edge k+NV+1, unless the outputs are held by a new round.
- Latency: first sample valid 1 cycle after the ena edge. Exactly NV consecutive valid cycles per tick. Minimum tick spacing is NV+1 cycles.
- Back-to-back: ena at edge k+NV+1 (first IDLE cycle) is accepted.
- Overrun: ena=1 while state=RUN is ignored, and ovr=1 for the following cycle. The round in progress is unaffected.
- Frequency writes:
  - Accepted every cycle regardless of state: frq[wr_addr] <= wr_frq at the edge.
  - If the write targets the voice being updated at that same edge, the update uses the old frq. The new value applies from the next round.
- phs_clr:
  - Sets all phase regs to 0 at the edge; takes priority over accumulation in that cycle.
  - Aborts a round in progress: returns to IDLE, busy=0, phs_vld=0 next cycle.
  - Frequency regs are unchanged.
  - ena and phs_clr in the same cycle: clear wins and the tick is dropped. ovr=0.
- phs holds its last value when phs_vld=0.

Decomposition:
- Shared package nco_pkg: state encodings (ST_IDLE, ST_RUN), default dsz/NV constants, voice-index type.
- One sub-module, nco_frq_regs: the NV x dsz frequency register file, with one synchronous write port and one combinational read port indexed by v. Phase storage and the adder stay in nco_voice_sched.

Test Plan:
- Reset, then NV=4, frq={1,2,3,4}, one ena -> phs_vld for 4 cycles starting 1 cycle after ena; phs=1,2,3,4; phs_voice=0,1,2,3; busy high 5 cycles.
- Wrap: frq[0]=0x800000, three ticks -> voice0 phs = 0x800000, 0x000000, 0x800000.
- Overrun: ena, then ena again 2 cycles later -> second tick ignored, ovr pulses once, round output unchanged.
- Write collision: wr_stb to voice 2 with value 0x10 on the cycle voice 2 updates (old frq 3) -> phs=+3 this round, +0x10 next round.
- Mid-round phs_clr during voice 1 -> busy=0 and phs_vld=0 next cycle; next tick gives phs=frq[i] for all voices.
- Mid-round reset -> all outputs 0 next cycle; frq regs 0, so the next tick yields phs=0 for all voices.
